// File: rtl/dma_ep_pkg.sv
// Shared types and constants for the DMA peripheral endpoint slice.
package dma_ep_pkg;

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    REQ  = 6'b000010,
    ACK  = 6'b000100,
    STRB = 6'b001000,
    REL  = 6'b010000,
    TC   = 6'b100000
  } ep_state_e;

  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;

endpackage

// File: rtl/dma_peripheral_endpoint_if.sv
// DREQ/DACK channel bus as seen between the DMA controller (master) and the I/O device (slave).
interface dma_peripheral_endpoint_if #(parameter int WIDTH = 8);
  logic             DREQ;
  logic             DACK;
  logic             IOR_N;
  logic             IOW_N;
  logic             EOP_N;
  logic [WIDTH-1:0] DB_IN;
  logic [WIDTH-1:0] DB_OUT;
  logic             DB_OE;

  modport master (input DREQ, DB_OUT, DB_OE, output DACK, IOR_N, IOW_N, EOP_N, DB_IN);
  modport slave  (output DREQ, DB_OUT, DB_OE, input DACK, IOR_N, IOW_N, EOP_N, DB_IN);
endinterface

// File: rtl/dma_ep_fifo.sv
// Synchronous FIFO with same-cycle push/pop, occupancy count and async reset.
module dma_ep_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic             doPush, doPop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/dma_peripheral_endpoint.sv
// Device side of an 8237-style DREQ/DACK channel: requests from FIFO level, answers strobes.
module dma_peripheral_endpoint
  import dma_ep_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int DEMAND = 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    enable,
  input  logic                    dir,
  dma_peripheral_endpoint_if.slave bus,
  input  logic                    lcl_wr_valid,
  input  logic [WIDTH-1:0]        lcl_wr_data,
  output logic                    lcl_wr_ready,
  output logic                    lcl_rd_valid,
  output logic [WIDTH-1:0]        lcl_rd_data,
  input  logic                    lcl_rd_ready,
  output logic [CW-1:0]           count,
  output logic                    tc_flag,
  input  logic                    tc_clr,
  output logic                    strobe_err
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ep_state_e        state, stNext;
  logic             full, empty, strobeLo, ready, inXfer, busOp;
  logic             fifoPush, fifoPop, pushEff, popEff, readyAfter;
  logic             dreq, oeNext, tcSet, errSet;
  logic             eopSeen, tcFlag, strobeErr, dbOe;
  logic [WIDTH-1:0] dbOut, dbCap, pushData, head;
  logic [CW-1:0]    cnt, cntAfter;

  assign strobeLo = (dir == DIR_MEM2DEV) ? !bus.IOW_N : !bus.IOR_N;
  assign ready    = (dir == DIR_MEM2DEV) ? (cnt < DEPTH_C) : (cnt != '0);
  assign inXfer   = (state == ACK) || (state == STRB);
  // The single FIFO op of a transfer happens on the first strobe-high cycle in STRB.
  assign busOp    = (state == STRB) && bus.DACK && !strobeLo;

  assign lcl_wr_ready = !full && (dir == DIR_DEV2MEM);
  assign lcl_rd_valid = !empty && (dir == DIR_MEM2DEV);
  assign lcl_rd_data  = head;
  assign count        = cnt;

  assign fifoPush = (dir == DIR_MEM2DEV) ? busOp : (lcl_wr_valid && lcl_wr_ready);
  assign fifoPop  = (dir == DIR_MEM2DEV) ? (lcl_rd_ready && lcl_rd_valid) : busOp;
  assign pushData = (dir == DIR_MEM2DEV) ? dbCap : lcl_wr_data;

  // Demand-mode continuation looks at the occupancy after this cycle's ops.
  assign pushEff    = fifoPush && !full;
  assign popEff     = fifoPop && !empty;
  assign cntAfter   = cnt + CW'(pushEff) - CW'(popEff);
  assign readyAfter = (dir == DIR_MEM2DEV) ? (cntAfter < DEPTH_C) : (cntAfter != '0);

  dma_ep_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) uFifo (
    .CLK(CLK), .RESET(RESET),
    .push(fifoPush), .pushData(pushData), .pop(fifoPop),
    .head(head), .count(cnt), .full(full), .empty(empty)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= stNext;
  end

  always_comb begin
    stNext = state;
    unique case (state)
      IDLE: if (enable && ready && !tcFlag) stNext = REQ;
      REQ: begin
        if (bus.DACK)    stNext = ACK;
        else if (!enable) stNext = IDLE;
      end
      ACK: begin
        if (!bus.DACK)    stNext = REL;
        else if (strobeLo) stNext = STRB;
      end
      STRB: begin
        if (!bus.DACK) stNext = REL;
        else if (!strobeLo) begin
          if (eopSeen || !bus.EOP_N)                   stNext = TC;
          else if (DEMAND != 0 && readyAfter && enable) stNext = ACK;
          else                                         stNext = REL;
        end
      end
      REL, TC: if (!bus.DACK) stNext = IDLE;
      default: stNext = IDLE;
    endcase
  end

  always_comb begin
    dreq   = (state == REQ) || (state == ACK) || (state == STRB);
    oeNext = (stNext == STRB) && (dir == DIR_DEV2MEM);
    tcSet  = (stNext == TC);
    errSet = !inXfer && bus.DACK && (!bus.IOR_N || !bus.IOW_N);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dbOe      <= 1'b0;
      dbOut     <= '0;
      dbCap     <= '0;
      eopSeen   <= 1'b0;
      tcFlag    <= 1'b0;
      strobeErr <= 1'b0;
    end else begin
      dbOe    <= oeNext;
      dbOut   <= oeNext ? head : '0;
      if (inXfer && !bus.IOW_N) dbCap <= bus.DB_IN;
      eopSeen <= inXfer && (eopSeen || !bus.EOP_N);
      if (tcSet)       tcFlag <= 1'b1;
      else if (tc_clr) tcFlag <= 1'b0;
      if (errSet)      strobeErr <= 1'b1;
      else if (tc_clr) strobeErr <= 1'b0;
    end
  end

  assign bus.DREQ   = dreq;
  assign bus.DB_OE  = dbOe;
  assign bus.DB_OUT = dbOut;
  assign tc_flag    = tcFlag;
  assign strobe_err = strobeErr;
endmodule

// File: tb/tb_dma_peripheral_endpoint.sv
// Directed bench: a demand-mode and a single-mode endpoint share one stimulus bus.
module tb_dma_peripheral_endpoint;
  import dma_ep_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic       enable, dir, dack, iorN, iowN, eopN, lwv, lrr, tcClr;
  logic [7:0] dbIn, lwd;
  int checks = 0;
  int failures = 0;

  dma_peripheral_endpoint_if #(.WIDTH(8)) busD ();
  dma_peripheral_endpoint_if #(.WIDTH(8)) busS ();
  assign busD.DACK = dack;  assign busS.DACK = dack;
  assign busD.IOR_N = iorN; assign busS.IOR_N = iorN;
  assign busD.IOW_N = iowN; assign busS.IOW_N = iowN;
  assign busD.EOP_N = eopN; assign busS.EOP_N = eopN;
  assign busD.DB_IN = dbIn; assign busS.DB_IN = dbIn;

  logic       wrRdyD, rdVldD, tcD, errD, wrRdyS, rdVldS, tcS, errS;
  logic [7:0] rdDataD, rdDataS;
  logic [3:0] cntD, cntS;

  dma_peripheral_endpoint #(.WIDTH(8), .DEPTH(8), .DEMAND(1)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .dir(dir), .bus(busD),
    .lcl_wr_valid(lwv), .lcl_wr_data(lwd), .lcl_wr_ready(wrRdyD),
    .lcl_rd_valid(rdVldD), .lcl_rd_data(rdDataD), .lcl_rd_ready(lrr),
    .count(cntD), .tc_flag(tcD), .tc_clr(tcClr), .strobe_err(errD));

  dma_peripheral_endpoint #(.WIDTH(8), .DEPTH(8), .DEMAND(0)) dutS (
    .CLK(CLK), .RESET(RESET), .enable(enable), .dir(dir), .bus(busS),
    .lcl_wr_valid(lwv), .lcl_wr_data(lwd), .lcl_wr_ready(wrRdyS),
    .lcl_rd_valid(rdVldS), .lcl_rd_data(rdDataS), .lcl_rd_ready(lrr),
    .count(cntS), .tc_flag(tcS), .tc_clr(tcClr), .strobe_err(errS));

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic doReset(input logic d);
    RESET = 1'b1; enable = 1'b0; dir = d; dack = 1'b0; iorN = 1'b1; iowN = 1'b1;
    eopN = 1'b1; dbIn = '0; lwv = 1'b0; lwd = '0; lrr = 1'b0; tcClr = 1'b0;
    step(2);
    RESET = 1'b0;
    step();
  endtask

  task automatic test_reset;
    doReset(1'b0);
    checks++; if (busD.DREQ !== 1'b0) begin failures++; $display("FAIL rst_dreq got=%b exp=0", busD.DREQ); end
    checks++; if (busD.DB_OE !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", busD.DB_OE); end
    checks++; if (busD.DB_OUT !== 8'h00) begin failures++; $display("FAIL rst_dbout got=%h exp=00", busD.DB_OUT); end
    checks++; if (cntD !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", cntD); end
    checks++; if (tcD !== 1'b0 || errD !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", tcD, errD); end
    lwv = 1'b1; lwd = 8'h99; step(); lwv = 1'b0;
    enable = 1'b1; step();
    dack = 1'b1; step();
    iorN = 1'b0; step();
    checks++; if (busD.DB_OE !== 1'b1 || busD.DB_OUT !== 8'h99) begin failures++; $display("FAIL strb_oe got=%b/%h exp=1/99", busD.DB_OE, busD.DB_OUT); end
    RESET = 1'b1; #1;
    checks++; if (busD.DREQ !== 1'b0 || busD.DB_OE !== 1'b0) begin failures++; $display("FAIL midrst_out got=%b%b exp=00", busD.DREQ, busD.DB_OE); end
    checks++; if (cntD !== 4'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", cntD); end
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL midrst_state got=%b exp=%b", dut.state, IDLE); end
    enable = 1'b0; dack = 1'b0; iorN = 1'b1;
    step(); RESET = 1'b0; step();
  endtask

  task automatic test_demand_read;
    doReset(1'b0);
    lwv = 1'b1; lwd = 8'hA5; step(); lwd = 8'h3C; step(); lwv = 1'b0;
    checks++; if (cntD !== 4'd2) begin failures++; $display("FAIL dr_fill got=%0d exp=2", cntD); end
    enable = 1'b1; step();
    checks++; if (busD.DREQ !== 1'b1) begin failures++; $display("FAIL dr_dreq got=%b exp=1", busD.DREQ); end
    dack = 1'b1; step();
    iorN = 1'b0; step();
    checks++; if (busD.DB_OE !== 1'b1 || busD.DB_OUT !== 8'hA5) begin failures++; $display("FAIL dr_word0 got=%b/%h exp=1/a5", busD.DB_OE, busD.DB_OUT); end
    step(2); iorN = 1'b1; step();
    checks++; if (cntD !== 4'd1 || busD.DB_OE !== 1'b0 || busD.DREQ !== 1'b1) begin failures++; $display("FAIL dr_pop0 got=%0d/%b/%b exp=1/0/1", cntD, busD.DB_OE, busD.DREQ); end
    iorN = 1'b0; step();
    checks++; if (busD.DB_OE !== 1'b1 || busD.DB_OUT !== 8'h3C) begin failures++; $display("FAIL dr_word1 got=%b/%h exp=1/3c", busD.DB_OE, busD.DB_OUT); end
    step(2); iorN = 1'b1; step();
    checks++; if (cntD !== 4'd0 || busD.DREQ !== 1'b0) begin failures++; $display("FAIL dr_pop1 got=%0d/%b exp=0/0", cntD, busD.DREQ); end
    step();
    checks++; if (dut.state !== REL) begin failures++; $display("FAIL dr_rel got=%b exp=%b", dut.state, REL); end
    dack = 1'b0; step(2);
    checks++; if (busD.DREQ !== 1'b0 || dut.state !== IDLE) begin failures++; $display("FAIL dr_idle got=%b/%b exp=0/%b", busD.DREQ, dut.state, IDLE); end
  endtask

  task automatic test_single_write;
    doReset(1'b1);
    enable = 1'b1; step();
    checks++; if (busS.DREQ !== 1'b1) begin failures++; $display("FAIL sw_dreq got=%b exp=1", busS.DREQ); end
    dack = 1'b1; step();
    iowN = 1'b0; dbIn = 8'h5A; step();
    iowN = 1'b1; dbIn = 8'hFF; step();
    checks++; if (cntS !== 4'd1 || rdDataS !== 8'h5A || rdVldS !== 1'b1) begin failures++; $display("FAIL sw_push got=%0d/%h/%b exp=1/5a/1", cntS, rdDataS, rdVldS); end
    checks++; if (busS.DREQ !== 1'b0) begin failures++; $display("FAIL sw_drop got=%b exp=0", busS.DREQ); end
    step();
    checks++; if (busS.DREQ !== 1'b0) begin failures++; $display("FAIL sw_hold got=%b exp=0", busS.DREQ); end
    dack = 1'b0; step(2);
    checks++; if (busS.DREQ !== 1'b1) begin failures++; $display("FAIL sw_rereq got=%b exp=1", busS.DREQ); end
    dack = 1'b1; step();
    iowN = 1'b0; dbIn = 8'h77; step(10);
    iowN = 1'b1; step(3);
    checks++; if (cntS !== 4'd2) begin failures++; $display("FAIL sw_long got=%0d exp=2", cntS); end
    lrr = 1'b1; step(); lrr = 1'b0;
    checks++; if (cntS !== 4'd1 || rdDataS !== 8'h77) begin failures++; $display("FAIL sw_lpop got=%0d/%h exp=1/77", cntS, rdDataS); end
    dack = 1'b0; enable = 1'b0; step();
  endtask

  task automatic test_tc;
    doReset(1'b1);
    enable = 1'b1; step();
    dack = 1'b1; step();
    for (int i = 0; i < 8; i++) begin
      iowN = 1'b0; dbIn = 8'(i + 1); eopN = (i == 7) ? 1'b0 : 1'b1; step();
      iowN = 1'b1; eopN = 1'b1; step();
    end
    checks++; if (cntD !== 4'd8 || rdDataD !== 8'h01) begin failures++; $display("FAIL tc_fill got=%0d/%h exp=8/01", cntD, rdDataD); end
    checks++; if (tcD !== 1'b1 || busD.DREQ !== 1'b0) begin failures++; $display("FAIL tc_set got=%b/%b exp=1/0", tcD, busD.DREQ); end
    dack = 1'b0; step(2);
    checks++; if (busD.DREQ !== 1'b0 || tcD !== 1'b1) begin failures++; $display("FAIL tc_hold got=%b/%b exp=0/1", busD.DREQ, tcD); end
    tcClr = 1'b1; step(); tcClr = 1'b0;
    checks++; if (tcD !== 1'b0) begin failures++; $display("FAIL tc_clr got=%b exp=0", tcD); end
    step(2);
    checks++; if (busD.DREQ !== 1'b0) begin failures++; $display("FAIL tc_full got=%b exp=0", busD.DREQ); end
  endtask

  task automatic test_simul;
    doReset(1'b0);
    lwv = 1'b1; lwd = 8'h22; step(); lwv = 1'b0;
    enable = 1'b1; step();
    dack = 1'b1; step();
    iorN = 1'b0; step();
    checks++; if (busD.DB_OUT !== 8'h22) begin failures++; $display("FAIL sim_dbout got=%h exp=22", busD.DB_OUT); end
    iorN = 1'b1; lwv = 1'b1; lwd = 8'h11; step(); lwv = 1'b0;
    checks++; if (cntD !== 4'd1 || rdDataD !== 8'h11) begin failures++; $display("FAIL sim_net got=%0d/%h exp=1/11", cntD, rdDataD); end
    checks++; if (busD.DREQ !== 1'b1) begin failures++; $display("FAIL sim_demand got=%b exp=1", busD.DREQ); end
    dack = 1'b0; enable = 1'b0; step(2);
  endtask

  task automatic test_errors;
    doReset(1'b0);
    lwv = 1'b1; lwd = 8'h44; step(); lwv = 1'b0;
    dack = 1'b1; iorN = 1'b0; step();
    iorN = 1'b1; step();
    checks++; if (errD !== 1'b1 || cntD !== 4'd1) begin failures++; $display("FAIL err_set got=%b/%0d exp=1/1", errD, cntD); end
    tcClr = 1'b1; dack = 1'b0; step(); tcClr = 1'b0;
    checks++; if (errD !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", errD); end
    enable = 1'b1; step();
    dack = 1'b1; step();
    dack = 1'b0; step();
    checks++; if (dut.state !== REL || busD.DREQ !== 1'b0 || cntD !== 4'd1) begin failures++; $display("FAIL abort got=%b/%b/%0d exp=%b/0/1", dut.state, busD.DREQ, cntD, REL); end
    step(2);
    checks++; if (busD.DREQ !== 1'b1) begin failures++; $display("FAIL abort_rereq got=%b exp=1", busD.DREQ); end
    enable = 1'b0; step(2);
  endtask

  initial begin
    test_reset();
    test_demand_read();
    test_single_write();
    test_tc();
    test_simul();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_peripheral_endpoint.md
Name: dma_peripheral_endpoint

Overview:
- I/O-side responder for the 8237-style DMA channel: the device at the far end of a DREQ/DACK channel.
- Raises DREQ from the fill level of a local FIFO and answers DACK-qualified IOR_N/IOW_N strobes.
  - IOR_N: drives the data bus from the FIFO.
  - IOW_N: captures the data bus into the FIFO.
- Latches terminal count on EOP_N.
- Used as the bus-side counterpart of the DMA timing FSM in system benches and as a reusable peripheral front-end.

Parameters:
- WIDTH, 8, data bus and FIFO word width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DEMAND, 1, 1 = demand mode (DREQ held across transfers while data/space remains); 0 = single mode (DREQ dropped after every transfer).

Ports:
- CLK  in  1  system clock, shared with the DMA controller.
- RESET  in  1  asynchronous, active-high reset.
- enable  in  1  channel enable; DREQ is never raised while low.
- dir  in  1  0 = device-to-memory (bus reads device via IOR_N); 1 = memory-to-device (bus writes device via IOW_N); changed only while idle with enable=0.
- DREQ  out  1  DMA request, active high.
- DACK  in  1  DMA acknowledge, active high.
- IOR_N  in  1  I/O read strobe, active low.
- IOW_N  in  1  I/O write strobe, active low.
- EOP_N  in  1  end of process / terminal count, active low.
- DB_IN  in  WIDTH  data bus input.
- DB_OUT  out  WIDTH  data bus drive value.
- DB_OE  out  1  data bus output enable.
- lcl_wr_valid  in  1  local push request (used when dir=0).
- lcl_wr_data  in  WIDTH  local push data.
- lcl_wr_ready  out  1  = !full && dir==0.
- lcl_rd_valid  out  1  = !empty && dir==1.
- lcl_rd_data  out  WIDTH  FIFO head.
- lcl_rd_ready  in  1  local pop request.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- tc_flag  out  1  sticky terminal-count flag.
- tc_clr  in  1  clears tc_flag.
- strobe_err  out  1  sticky: a strobe occurred outside an acknowledged transfer; cleared by tc_clr.

Behaviour:
- Reset (async, on RESET high): state=IDLE; DREQ=0, DB_OE=0, DB_OUT=0, count=0, FIFO pointers 0, tc_flag=0, strobe_err=0.
- All bus inputs are synchronous to CLK and sampled directly; there are no synchronizers.
- Ready condition: dir=0 requires count>0; dir=1 requires count<DEPTH.
- Active strobe: IOR_N when dir=0, IOW_N when dir=1.
- FSM states:
  - IDLE: DREQ=0. Go to REQ when enable && ready condition.
  - REQ: DREQ=1. Go to ACK when DACK=1. Go to IDLE when enable=0 and DACK=0.
  - ACK: DREQ=1. Go to STRB when the active strobe is low and DACK=1.
    - dir=0: DB_OE and DB_OUT are registered, asserted the cycle after IOR_N is first seen low; DB_OUT=FIFO head.
  - STRB: holds while the strobe is low.
    - DB_IN is captured every cycle while IOW_N is low.
    - On the first cycle the strobe is high, one FIFO op occurs: dir=0 pops, dir=1 pushes the last captured DB_IN. DB_OE drops the same cycle.
    - Next state, in priority order:
      1. EOP_N seen low at any point in ACK/STRB → TC.
      2. DEMAND=1 and ready condition still true (after the op) and DACK=1 → ACK.
      3. Otherwise → REL.
  - REL: DREQ=0; go to IDLE when DACK=0.
  - TC: DREQ=0; tc_flag set; go to IDLE when DACK=0. DREQ stays low while tc_flag=1.
- Exactly one bus transfer per strobe low-to-high; extended strobes of any length give a single op.
- Local/bus simultaneity: a same-cycle local op and bus op are both applied; count changes by net (+1 − 1 = 0).
  - Local push when full and local pop when empty are ignored.
  - A bus push when full cannot occur, because the ready condition gates ACK entry.
- DACK=0 during ACK/STRB (aborted transfer): drop DB_OE, no FIFO op, go to REL.
- Strobe low while not in ACK/STRB with DACK=1: ignored; sets strobe_err.
- EOP_N low in IDLE/REQ is ignored.
- tc_clr together with tc set: set wins.
- enable falling mid-transfer: the current transfer completes; afterwards go to REL.

Decomposition:
- Package dma_ep_pkg holds:
  - ep_state_e: IDLE, REQ, ACK, STRB, REL, TC (one-hot encoded, matching the controller FSM style).
  - DIR_DEV2MEM=0, DIR_MEM2DEV=1.
- Sub-module dma_ep_fifo: synchronous FIFO with simultaneous push/pop, count, full/empty, async reset. The top block holds the FSM, strobe edge detect and data capture.

Test Plan:
- Reset mid-STRB with DB_OE=1 → next cycle DREQ=0, DB_OE=0, count=0, state IDLE.
- dir=0, DEMAND=1, push 0xA5,0x3C locally, enable=1 → DREQ=1; DACK=1 plus two IOR_N pulses (3 cycles low each) → DB_OUT 0xA5 then 0x3C, count 2→1→0, DREQ drops after the second pulse, REL until DACK=0.
- dir=1, DEMAND=0, IOW_N pulse with DB_IN=0x5A → count=1, lcl_rd_data=0x5A, DREQ low until DACK drops then reasserts; IOW_N held low 10 cycles → exactly one push.
- dir=1, DEPTH=8, 8 writes with EOP_N low on the 8th → count=8, tc_flag=1, DREQ stays 0 after DACK drops; tc_clr → tc_flag=0, DREQ stays 0 (full).
- dir=0, count=1, local push 0x11 on the same cycle IOR_N rises → count stays 1, head=0x11.
- IOR_N pulse with DACK=1 in IDLE → strobe_err=1, no FIFO change; DACK dropped in ACK → REL, no op.
